shared_ram_port: RTL and testbench
==================================

# shared_ram_port

Single-port RAM access controller that sits directly downstream of the two-requester grant arbiter. It consumes the arbiter's gnt_0/gnt_1 together with each requester's command (req, we, addr, wdata). It performs at most one RAM access per cycle on behalf of the owning port, and returns read data and per-port completion pulses. An ownership state machine inserts a one-cycle turnaround on every owner change and flags illegal double grants.

## Interface
- DATA_W, 8, RAM word width in bits
- ADDR_W, 4, address width; RAM depth = 2**ADDR_W words
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- gnt_0  in  1  grant to port 0 from arbiter
- gnt_1  in  1  grant to port 1 from arbiter
- req_0, req_1  in  1  port is presenting a command this cycle
- we_0, we_1  in  1  1 = write, 0 = read
- addr_0, addr_1  in  ADDR_W  word address
- wdata_0, wdata_1  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid when rvalid_0 or rvalid_1 is high
- rvalid_0, rvalid_1  out  1  one-cycle read-complete pulse
- wack_0, wack_1  out  1  one-cycle write-complete pulse
- owner  out  2  current state encoding (see Operation)
- err  out  1  sticky double-grant error

## Operation
- States (owner encoding): IDLE=00, OWN0=01, OWN1=10, TURN=11. TURN holds a 1-bit internal target register.
- Access rule: a port x is accepted in a cycle iff state==OWNx, gnt_x=1, gnt_other=0, and req_x=1. At most one access per cycle. we_x selects write vs read.
- Transitions, evaluated in priority order:
  - gnt_0 && gnt_1, in any state: next = IDLE; err set to 1 and held until reset. No access that cycle.
  - IDLE:
    - gnt_0 only -> OWN0.
    - gnt_1 only -> OWN1.
    - No grant -> stay in IDLE.
    - No access is performed in IDLE.
  - OWN0:
    - gnt_1 only -> TURN with target=1.
    - Otherwise stay in OWN0, including when neither grant is high.
    - OWN1 mirrors OWN0 (gnt_0 only -> TURN with target=0).
  - TURN, no access:
    - Next = OWN<target> if gnt_<target> only.
    - Next = TURN with target flipped if only the other grant is high.
    - Next = IDLE if neither grant is high.
- Write: mem[addr_x] <= wdata_x at the accepting edge; wack_x pulses high on the following cycle.
- Read: rdata <= mem[addr_x] at the accepting edge; rvalid_x pulses high on the following cycle. rdata holds its value until the next accepted read.
- A grant held without req (the arbiter holds gnt after req drops) keeps ownership and performs no access.
- The RAM array is not reset. Contents persist across reset.
- Address width exactly indexes depth. There is no out-of-range case.

## Timing
- Reset values (next edge with reset=1):
  - state=IDLE, owner=00, target=0.
  - rdata=0, rvalid_0=rvalid_1=0, wack_0=wack_1=0, err=0.
- reset has priority over every other input. A mid-operation reset discards any access presented in that cycle: no memory write, no pulse on the next cycle.
- Latency: command accepted at edge N -> rvalid/wack and rdata visible after edge N (cycle N+1). Back-to-back accesses from the owning port sustain 1 access per cycle.
- Grant-to-first-access:
  - From IDLE: one cycle of grant before the first access is accepted.
  - From the other owner: one TURN cycle, then ownership, then access. The first access lands two edges after the new grant is first seen.
- At most one of rvalid_0, rvalid_1, wack_0, wack_1 is high in any cycle.

## Test plan
- Reset: assert reset for 2 cycles mid-stream -> all outputs 0, owner=00. Memory written before reset reads back unchanged afterwards.
- Port 0 write/read: gnt_0=1, then req_0, we_0=1, addr_0=3, wdata_0=0xA5 -> wack_0 next cycle. Then a read of addr 3 -> rvalid_0 next cycle with rdata=0xA5.
- Owner switch:
  - In OWN0, drop gnt_0 and raise gnt_1 with req_1 read of addr 3 held -> owner sequence 01, 11, 10.
  - The read is accepted only in OWN1, then rvalid_1 with rdata=0xA5.
  - No pulse during TURN.
- Grant without request: gnt_1=1, req_1=0 for 5 cycles -> owner=10, no rvalid/wack, memory unchanged.
- Double grant: gnt_0=gnt_1=1 with req_0 write -> no write, err=1, owner=00. err stays 1 after grants clear, until reset.
- Back-to-back: OWN1, 4 consecutive reads of addr 0..3 -> 4 consecutive rvalid_1 pulses with matching data, 1 per cycle.

Source files
------------

// File: rtl/shared_ram_port.sv
// ---------------------------------------------------------------------------
// shared_ram_port
//
// Single-port RAM access controller placed directly after a two-requester
// grant arbiter. At most one RAM access is made per cycle, on behalf of the
// port that currently owns the RAM. Each completed access produces a
// one-cycle pulse on the following cycle.
//
// Changing owner always passes through a one-cycle TURN state. A cycle in
// which both grants are high is illegal: no access is made and a sticky
// error flag is raised.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-high reset
//   gnt_0, gnt_1       grants from the arbiter
//   req_x, we_x        command valid / write-not-read, per port
//   addr_x, wdata_x    word address / write data, per port
//   rdata              read data, held until the next accepted read
//   rvalid_x, wack_x   one-cycle read / write completion pulses
//   owner              state encoding: 00 IDLE, 01 OWN0, 10 OWN1, 11 TURN
//   err                sticky double-grant error
// ---------------------------------------------------------------------------
module shared_ram_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic              wack_0,
  output logic              wack_1,
  output logic [1:0]        owner,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;
  localparam logic [1:0] S_TURN = 2'b11;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q,  state_d;
  logic              target_q, target_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_0_q, rvalid_1_q, wack_0_q, wack_1_q;

  logic              acc_0, acc_1;
  logic              acc_wr, acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Ownership FSM and access decode.
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    err_d    = err_q;
    acc_0    = 1'b0;
    acc_1    = 1'b0;

    if (gnt_0 && gnt_1) begin
      // Illegal double grant wins over everything else.
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      // Double grant already excluded, so gnt_x alone means "x only".
      acc_0 = (state_q == S_OWN0) && gnt_0 && req_0;
      acc_1 = (state_q == S_OWN1) && gnt_1 && req_1;

      case (state_q)
        S_IDLE: begin
          if (gnt_0)      state_d = S_OWN0;
          else if (gnt_1) state_d = S_OWN1;
        end
        S_OWN0: begin
          // Losing all grants keeps ownership; only the other grant moves us.
          if (gnt_1) begin
            state_d  = S_TURN;
            target_d = 1'b1;
          end
        end
        S_OWN1: begin
          if (gnt_0) begin
            state_d  = S_TURN;
            target_d = 1'b0;
          end
        end
        default: begin // S_TURN
          if (!gnt_0 && !gnt_1) begin
            state_d = S_IDLE;
          end else if (target_q ? gnt_1 : gnt_0) begin
            state_d = target_q ? S_OWN1 : S_OWN0;
          end else begin
            // Grant swung back to the other port during the turnaround.
            target_d = ~target_q;
          end
        end
      endcase
    end
  end

  // Only one port can be accepted per cycle, so a single mux feeds the RAM.
  assign acc_addr  = acc_1 ? addr_1  : addr_0;
  assign acc_wdata = acc_1 ? wdata_1 : wdata_0;
  assign acc_wr    = (acc_0 && we_0)  || (acc_1 && we_1);
  assign acc_rd    = (acc_0 && !we_0) || (acc_1 && !we_1);

  // NOTE: the RAM array has no reset so it maps onto a plain memory macro and
  // its contents survive reset; reset only suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && acc_wr) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      wack_0_q   <= 1'b0;
      wack_1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      err_q      <= err_d;
      rvalid_0_q <= acc_0 && !we_0;
      rvalid_1_q <= acc_1 && !we_1;
      wack_0_q   <= acc_0 && we_0;
      wack_1_q   <= acc_1 && we_1;
      if (acc_rd) begin
        rdata_q <= mem[acc_addr];
      end
    end
  end

  assign owner    = state_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign rvalid_0 = rvalid_0_q;
  assign rvalid_1 = rvalid_1_q;
  assign wack_0   = wack_0_q;
  assign wack_1   = wack_1_q;

endmodule

// File: tb/tb_shared_ram_port.sv
// ---------------------------------------------------------------------------
// tb_shared_ram_port
//
// Directed sequence followed by a randomized stretch. Each cycle the
// outputs are compared with a behavioural model that holds the RAM as a
// plain array and the owner as the visible 2-bit code.
// ---------------------------------------------------------------------------
module tb_shared_ram_port;

  logic       clock = 1'b0;
  logic       reset;
  logic       gnt_0, gnt_1, req_0, req_1, we_0, we_1;
  logic [3:0] addr_0, addr_1;
  logic [7:0] wdata_0, wdata_1;
  logic [7:0] rdata;
  logic       rvalid_0, rvalid_1, wack_0, wack_1;
  logic [1:0] owner;
  logic       err;

  always #5 clock = ~clock;

  shared_ram_port #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .req_0(req_0), .req_1(req_1),
    .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .rdata(rdata),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .wack_0(wack_0), .wack_1(wack_1),
    .owner(owner), .err(err)
  );

  // Behavioural model
  logic [7:0] m_mem [16];
  logic [1:0] m_owner;
  logic       m_target, m_err;
  logic [7:0] m_rdata;
  logic       m_rv0, m_rv1, m_wk0, m_wk1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, g0, g1, r0, w0, input logic [3:0] a0,
                       input logic [7:0] d0, input logic r1, w1,
                       input logic [3:0] a1, input logic [7:0] d1);
    if (rst) begin
      m_owner = 2'b00; m_target = 1'b0; m_err = 1'b0; m_rdata = 8'h00;
      {m_rv0, m_rv1, m_wk0, m_wk1} = 4'b0000;
      return;
    end
    {m_rv0, m_rv1, m_wk0, m_wk1} = 4'b0000;
    if (g0 && g1) begin
      m_err   = 1'b1;
      m_owner = 2'b00;
      return;
    end
    // Accepted access, judged against the owner before this edge.
    if (m_owner == 2'b01 && g0 && r0) begin
      if (w0) begin m_mem[a0] = d0; m_wk0 = 1'b1; end
      else    begin m_rdata = m_mem[a0]; m_rv0 = 1'b1; end
    end
    if (m_owner == 2'b10 && g1 && r1) begin
      if (w1) begin m_mem[a1] = d1; m_wk1 = 1'b1; end
      else    begin m_rdata = m_mem[a1]; m_rv1 = 1'b1; end
    end
    // Ownership movement.
    if (m_owner == 2'b00) begin
      if (g0) m_owner = 2'b01;
      else if (g1) m_owner = 2'b10;
    end else if (m_owner == 2'b01) begin
      if (g1) begin m_owner = 2'b11; m_target = 1'b1; end
    end else if (m_owner == 2'b10) begin
      if (g0) begin m_owner = 2'b11; m_target = 1'b0; end
    end else begin
      if (!g0 && !g1) m_owner = 2'b00;
      else if (m_target == 1'b1 && g1) m_owner = 2'b10;
      else if (m_target == 1'b0 && g0) m_owner = 2'b01;
      else m_target = ~m_target;
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge, compare.
  task automatic cyc(input string tag, input logic rst, g0, g1, r0, w0,
                     input logic [3:0] a0, input logic [7:0] d0,
                     input logic r1, w1, input logic [3:0] a1, input logic [7:0] d1);
    reset = rst; gnt_0 = g0; gnt_1 = g1;
    req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
    req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
    model(rst, g0, g1, r0, w0, a0, d0, r1, w1, a1, d1);
    @(posedge clock);
    #1;
    check({tag, " outputs"},
          {17'd0, owner, err, rvalid_0, rvalid_1, wack_0, wack_1, rdata},
          {17'd0, m_owner, m_err, m_rv0, m_rv1, m_wk0, m_wk1, m_rdata});
    check({tag, " one-pulse"}, 32'($countones({rvalid_0, rvalid_1, wack_0, wack_1}) <= 1), 32'd1);
  endtask

  // Shorthands for the directed part.
  task automatic p0(input string tag, input logic g0, g1, r0, w0,
                    input logic [3:0] a, input logic [7:0] d);
    cyc(tag, 1'b0, g0, g1, r0, w0, a, d, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic p1(input string tag, input logic g0, g1, r1, w1,
                    input logic [3:0] a, input logic [7:0] d);
    cyc(tag, 1'b0, g0, g1, 1'b0, 1'b0, 4'h0, 8'h00, r1, w1, a, d);
  endtask

  initial begin
    logic g0, g1;
    logic [7:0] keep5, keep6;

    // Reset
    cyc("reset_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    cyc("reset_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    check("reset owner", 32'(owner), 32'd0);
    check("reset err", 32'(err), 32'd0);

    // Fill the RAM so every later read has a known value.
    p0("grant0", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    check("own0 after grant", 32'(owner), 32'd1);
    for (int i = 0; i < 16; i++) p0("fill", 1'b1, 1'b0, 1'b1, 1'b1, 4'(i), 8'(i * 29 + 7));

    // Port 0 write/read
    p0("wr3", 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
    check("wack_0 after write", 32'(wack_0), 32'd1);
    p0("rd3", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    check("rvalid_0 read", 32'(rvalid_0), 32'd1);
    check("rdata addr3", 32'(rdata), 32'hA5);

    // Owner switch with port-1 read held throughout
    p1("sw_turn", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    check("switch turn", 32'(owner), 32'd3);
    p1("sw_own1", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    check("switch own1", 32'(owner), 32'd2);
    check("no pulse in turn", 32'({rvalid_0, rvalid_1, wack_0, wack_1}), 32'd0);
    p1("sw_acc", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    check("switch rvalid_1", 32'(rvalid_1), 32'd1);
    check("switch rdata", 32'(rdata), 32'hA5);

    // Grant held without request
    for (int i = 0; i < 5; i++) p1("noreq", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 8'hEE);
    check("noreq owner", 32'(owner), 32'd2);

    // Back-to-back reads from OWN1
    for (int i = 0; i < 4; i++) begin
      p1("b2b", 1'b0, 1'b1, 1'b1, 1'b0, 4'(i), 8'h00);
      check("b2b rvalid_1", 32'(rvalid_1), 32'd1);
    end
    p1("b2b_end", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    // Double grant with a port-0 write: no write, sticky err
    keep5 = m_mem[5];
    p0("dbl", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 8'hFF);
    check("dbl err", 32'(err), 32'd1);
    check("dbl owner", 32'(owner), 32'd0);
    p0("dbl_clr", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    p0("dbl_clr", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    check("err sticky", 32'(err), 32'd1);
    p0("g0_again", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    p0("rd5", 1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    check("addr5 unchanged", 32'(rdata), 32'(keep5));

    // Mid-operation reset discards the presented write; RAM persists
    keep6 = m_mem[6];
    cyc("rst_mid_a", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
    cyc("rst_mid_b", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
    check("reset clears err", 32'(err), 32'd0);
    check("no wack after reset", 32'(wack_0), 32'd0);
    p0("g0_post", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    p0("rd6", 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 8'h00);
    check("addr6 persists", 32'(rdata), 32'(keep6));
    p0("rd3b", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    check("addr3 persists", 32'(rdata), 32'hA5);

    // Randomized stretch; grants change every few cycles like a real arbiter.
    g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 19))
          0:               begin g0 = 1'b1; g1 = 1'b1; end
          1, 2, 3, 4, 5, 6, 7: begin g0 = 1'b1; g1 = 1'b0; end
          8, 9, 10, 11, 12, 13, 14: begin g0 = 1'b0; g1 = 1'b1; end
          default:         begin g0 = 1'b0; g1 = 1'b0; end
        endcase
      end
      cyc("rand", ($urandom_range(0, 59) == 0), g0, g1,
          1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
